// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - multi-account ATM session controller with lockout, transfer, limits and timeout
module atm_session_ctrl #(
  parameter int NUM_ACCOUNTS   = 16,
  parameter int CARD_WIDTH     = 4,
  parameter int PSW_WIDTH      = 16,
  parameter int BAL_WIDTH      = 20,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int WD_LIMIT       = 5000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [CARD_WIDTH-1:0] cfg_card,
  input  logic [PSW_WIDTH-1:0]  cfg_psw,
  input  logic [BAL_WIDTH-1:0]  cfg_bal,
  input  logic                  card_in,
  input  logic [CARD_WIDTH-1:0] card_number,
  input  logic                  psw_valid,
  input  logic [PSW_WIDTH-1:0]  password_input,
  input  logic                  op_valid,
  input  logic [1:0]            operation,
  input  logic [BAL_WIDTH-1:0]  value,
  input  logic [CARD_WIDTH-1:0] dest_card,
  input  logic                  svc_valid,
  input  logic                  another_service,
  output logic [BAL_WIDTH-1:0]  balance_out,
  output logic                  op_done,
  output logic                  error,
  output logic [2:0]            err_code,
  output logic                  wrong_psw,
  output logic                  card_locked,
  output logic                  card_out,
  output logic                  busy
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDX_W = CARD_WIDTH + 1;

  localparam logic [2:0] E_BAD_CARD = 3'd1;
  localparam logic [2:0] E_LOCKED   = 3'd2;
  localparam logic [2:0] E_INSUFF   = 3'd3;
  localparam logic [2:0] E_OVERFLOW = 3'd4;
  localparam logic [2:0] E_BAD_DEST = 3'd5;
  localparam logic [2:0] E_LIMIT    = 3'd6;
  localparam logic [2:0] E_TIMEOUT  = 3'd7;

  localparam logic [1:0] OP_INQ = 2'b00;
  localparam logic [1:0] OP_DEP = 2'b01;
  localparam logic [1:0] OP_WD  = 2'b10;
  localparam logic [1:0] OP_XFR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PIN,
    S_MENU,
    S_WAIT_SVC,
    S_EJECT
  } state_t;

  state_t                state_q, state_d;
  logic [CARD_WIDTH-1:0] acct_q, acct_d;
  logic [BAL_WIDTH-1:0]  wd_total_q, wd_total_d;
  logic [TMR_W-1:0]      timer_q, timer_d;

  logic [PSW_WIDTH-1:0]  psw_q   [NUM_ACCOUNTS];
  logic [PSW_WIDTH-1:0]  psw_d   [NUM_ACCOUNTS];
  logic [BAL_WIDTH-1:0]  bal_q   [NUM_ACCOUNTS];
  logic [BAL_WIDTH-1:0]  bal_d   [NUM_ACCOUNTS];
  logic [TRY_W-1:0]      tries_q [NUM_ACCOUNTS];
  logic [TRY_W-1:0]      tries_d [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] lock_q, lock_d;

  logic [BAL_WIDTH-1:0]  balance_out_q, balance_out_d;
  logic                  op_done_q, op_done_d;
  logic                  error_q, error_d;
  logic [2:0]            err_code_q, err_code_d;
  logic                  wrong_psw_q, wrong_psw_d;
  logic                  card_locked_q, card_locked_d;
  logic                  card_out_q, card_out_d;
  logic                  busy_q, busy_d;

  logic                  strobe_acc;
  logic                  timed_state;
  logic                  timeout;
  logic [BAL_WIDTH-1:0]  cur_bal;
  logic [BAL_WIDTH-1:0]  dst_bal;
  logic [BAL_WIDTH:0]    dep_sum;
  logic [BAL_WIDTH:0]    xfer_sum;
  logic [BAL_WIDTH:0]    wd_sum;
  logic                  dest_bad;

  // Card indices are compared one bit wider so a table that fills the whole index space still checks cleanly
  function automatic logic in_range(input logic [CARD_WIDTH-1:0] c);
    return {1'b0, c} < IDX_W'(NUM_ACCOUNTS);
  endfunction

  assign cur_bal     = bal_q[acct_q];
  assign dst_bal     = bal_q[dest_card];
  assign dep_sum     = {1'b0, cur_bal} + {1'b0, value};
  assign xfer_sum    = {1'b0, dst_bal} + {1'b0, value};
  // Session total never exceeds WD_LIMIT, so one extra bit keeps this sum exact
  assign wd_sum      = {1'b0, wd_total_q} + {1'b0, value};
  assign dest_bad    = !in_range(dest_card) || (dest_card == acct_q) || lock_q[dest_card];
  assign timed_state = (state_q == S_PIN) || (state_q == S_MENU) || (state_q == S_WAIT_SVC);
  assign timeout     = timed_state && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

  // Session FSM, account table updates and registered output values
  always_comb begin
    state_d       = state_q;
    acct_d        = acct_q;
    wd_total_d    = wd_total_q;
    psw_d         = psw_q;
    bal_d         = bal_q;
    tries_d       = tries_q;
    lock_d        = lock_q;
    balance_out_d = balance_out_q;
    err_code_d    = err_code_q;
    op_done_d     = 1'b0;
    error_d       = 1'b0;
    wrong_psw_d   = 1'b0;
    card_locked_d = 1'b0;
    card_out_d    = 1'b0;
    strobe_acc    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          if (in_range(cfg_card)) begin
            psw_d[cfg_card]   = cfg_psw;
            bal_d[cfg_card]   = cfg_bal;
            lock_d[cfg_card]  = 1'b0;
            tries_d[cfg_card] = '0;
          end
        end else if (card_in) begin
          if (!in_range(card_number)) begin
            error_d    = 1'b1;
            err_code_d = E_BAD_CARD;
            state_d    = S_EJECT;
          end else if (lock_q[card_number]) begin
            error_d    = 1'b1;
            err_code_d = E_LOCKED;
            state_d    = S_EJECT;
          end else begin
            acct_d     = card_number;
            wd_total_d = '0;
            state_d    = S_PIN;
          end
        end
      end

      S_PIN: begin
        if (psw_valid) begin
          strobe_acc = 1'b1;
          if (password_input == psw_q[acct_q]) begin
            tries_d[acct_q] = '0;
            state_d         = S_MENU;
          end else begin
            wrong_psw_d = 1'b1;
            if (tries_q[acct_q] == TRY_W'(MAX_TRIES - 1)) begin
              tries_d[acct_q] = TRY_W'(MAX_TRIES);
              lock_d[acct_q]  = 1'b1;
              card_locked_d   = 1'b1;
              state_d         = S_EJECT;
            end else begin
              tries_d[acct_q] = tries_q[acct_q] + TRY_W'(1);
            end
          end
        end else if (timeout) begin
          error_d    = 1'b1;
          err_code_d = E_TIMEOUT;
          state_d    = S_EJECT;
        end
      end

      S_MENU: begin
        if (op_valid) begin
          strobe_acc    = 1'b1;
          state_d       = S_WAIT_SVC;
          balance_out_d = cur_bal;
          case (operation)
            OP_INQ: begin
              op_done_d = 1'b1;
            end
            OP_DEP: begin
              if (dep_sum[BAL_WIDTH]) begin
                error_d    = 1'b1;
                err_code_d = E_OVERFLOW;
              end else begin
                bal_d[acct_q] = dep_sum[BAL_WIDTH-1:0];
                balance_out_d = dep_sum[BAL_WIDTH-1:0];
                op_done_d     = 1'b1;
              end
            end
            OP_WD: begin
              if (value > cur_bal) begin
                error_d    = 1'b1;
                err_code_d = E_INSUFF;
              end else if (wd_sum > (BAL_WIDTH + 1)'(WD_LIMIT)) begin
                error_d    = 1'b1;
                err_code_d = E_LIMIT;
              end else begin
                bal_d[acct_q] = cur_bal - value;
                balance_out_d = cur_bal - value;
                wd_total_d    = wd_sum[BAL_WIDTH-1:0];
                op_done_d     = 1'b1;
              end
            end
            OP_XFR: begin
              if (dest_bad) begin
                error_d    = 1'b1;
                err_code_d = E_BAD_DEST;
              end else if (value > cur_bal) begin
                error_d    = 1'b1;
                err_code_d = E_INSUFF;
              end else if (xfer_sum[BAL_WIDTH]) begin
                error_d    = 1'b1;
                err_code_d = E_OVERFLOW;
              end else begin
                bal_d[acct_q]    = cur_bal - value;
                bal_d[dest_card] = xfer_sum[BAL_WIDTH-1:0];
                balance_out_d    = cur_bal - value;
                op_done_d        = 1'b1;
              end
            end
            default: ;
          endcase
        end else if (timeout) begin
          error_d    = 1'b1;
          err_code_d = E_TIMEOUT;
          state_d    = S_EJECT;
        end
      end

      S_WAIT_SVC: begin
        if (svc_valid) begin
          strobe_acc = 1'b1;
          state_d    = another_service ? S_MENU : S_EJECT;
        end else if (timeout) begin
          error_d    = 1'b1;
          err_code_d = E_TIMEOUT;
          state_d    = S_EJECT;
        end
      end

      S_EJECT: begin
        card_out_d    = 1'b1;
        balance_out_d = '0;
        err_code_d    = '0;
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);

    // Inactivity timer restarts on any state change or accepted strobe
    if (!timed_state || strobe_acc || (state_d != state_q)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  // State, account table and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      acct_q        <= '0;
      wd_total_q    <= '0;
      timer_q       <= '0;
      lock_q        <= '0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        psw_q[i]   <= '0;
        bal_q[i]   <= '0;
        tries_q[i] <= '0;
      end
      balance_out_q <= '0;
      op_done_q     <= 1'b0;
      error_q       <= 1'b0;
      err_code_q    <= '0;
      wrong_psw_q   <= 1'b0;
      card_locked_q <= 1'b0;
      card_out_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acct_q        <= acct_d;
      wd_total_q    <= wd_total_d;
      timer_q       <= timer_d;
      lock_q        <= lock_d;
      psw_q         <= psw_d;
      bal_q         <= bal_d;
      tries_q       <= tries_d;
      balance_out_q <= balance_out_d;
      op_done_q     <= op_done_d;
      error_q       <= error_d;
      err_code_q    <= err_code_d;
      wrong_psw_q   <= wrong_psw_d;
      card_locked_q <= card_locked_d;
      card_out_q    <= card_out_d;
      busy_q        <= busy_d;
    end
  end

  assign balance_out = balance_out_q;
  assign op_done     = op_done_q;
  assign error       = error_q;
  assign err_code    = err_code_q;
  assign wrong_psw   = wrong_psw_q;
  assign card_locked = card_locked_q;
  assign card_out    = card_out_q;
  assign busy        = busy_q;

endmodule
